// File: rtl/lpc_post_snoop_if.sv
// lpc_post_snoop_if: LPC LAD/LFRAME# pin bundle; the snooper only ever listens.
interface lpc_post_snoop_if;
    logic [3:0] lpc_lad;
    logic       lpc_lframe_n;
    modport master (output lpc_lad, output lpc_lframe_n);
    modport slave  (input  lpc_lad, input  lpc_lframe_n);
endinterface

// File: rtl/lpc_post_snoop.sv
// lpc_post_snoop: listen-only LPC decoder capturing I/O write data to the POST code port.
module lpc_post_snoop #(
    parameter logic [15:0] PORT_ADDR = 16'h0080,
    parameter logic [15:0] ADDR_MASK = 16'hFFFF
) (
    input  logic                 lpc_clk,
    input  logic                 lpc_lreset,
    lpc_post_snoop_if.slave      bus,
    output logic [7:0]           code,
    output logic                 code_valid,
    output logic [7:0]           write_count,
    output logic [7:0]           abort_count,
    output logic                 frame_active
);
    typedef enum logic [3:0] {IDLE, CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, DATA0, DATA1, SKIP} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_addr;
    logic [3:0]  r_data_lo;
    logic        w_capture, w_match, w_in_frame, w_abort, w_addr_phase, w_next_in_frame;

    assign w_match         = (r_addr & ADDR_MASK) == (PORT_ADDR & ADDR_MASK);
    assign w_in_frame      = r_state inside {CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, DATA0, DATA1};
    assign w_next_in_frame = w_next inside {CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, DATA0, DATA1};
    assign w_abort         = !bus.lpc_lframe_n && bus.lpc_lad == 4'hF && w_in_frame;
    assign w_addr_phase    = bus.lpc_lframe_n && r_state inside {ADDR0, ADDR1, ADDR2, ADDR3};

    // LFRAME# low overrides every state, so a new START or abort always wins
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        if (!bus.lpc_lframe_n)
            w_next = (bus.lpc_lad == 4'h0) ? CTDIR : (bus.lpc_lad == 4'hF) ? IDLE : SKIP;
        else
            case (r_state)
                CTDIR:   w_next = (bus.lpc_lad == 4'b0010) ? ADDR0 : SKIP;
                ADDR0:   w_next = ADDR1;
                ADDR1:   w_next = ADDR2;
                ADDR2:   w_next = ADDR3;
                ADDR3:   w_next = DATA0;
                DATA0:   w_next = DATA1;
                DATA1: begin
                    w_next    = SKIP;
                    w_capture = w_match;
                end
                default: w_next = r_state;
            endcase
    end

    always_ff @(posedge lpc_clk or posedge lpc_lreset) begin
        if (lpc_lreset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data_lo    <= '0;
            code         <= '0;
            code_valid   <= 1'b0;
            write_count  <= '0;
            abort_count  <= '0;
            frame_active <= 1'b0;
        end else begin
            r_state      <= w_next;
            frame_active <= w_next_in_frame;
            code_valid   <= w_capture;
            if (!bus.lpc_lframe_n && bus.lpc_lad == 4'h0)
                r_addr <= '0;
            else if (w_addr_phase)
                r_addr <= {r_addr[11:0], bus.lpc_lad};
            if (bus.lpc_lframe_n && r_state == DATA0)
                r_data_lo <= bus.lpc_lad;
            if (w_capture) begin
                code        <= {bus.lpc_lad, r_data_lo};
                write_count <= write_count + 8'd1;
            end
            if (w_abort && abort_count != 8'hFF)
                abort_count <= abort_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_lpc_post_snoop.sv
// tb_lpc_post_snoop: frame-level reference model checking two snoopers (exact and 0x80-0x83 mask).
module tb_lpc_post_snoop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lpc_post_snoop_if bus ();
    logic [7:0] a_code, a_wc, a_ac, b_code, b_wc, b_ac;
    logic       a_cv, a_fa, b_cv, b_fa;

    lpc_post_snoop #(.PORT_ADDR(16'h0080), .ADDR_MASK(16'hFFFF)) dut_a (
        .lpc_clk(clk), .lpc_lreset(rst), .bus(bus.slave), .code(a_code), .code_valid(a_cv),
        .write_count(a_wc), .abort_count(a_ac), .frame_active(a_fa));
    lpc_post_snoop #(.PORT_ADDR(16'h0080), .ADDR_MASK(16'hFFFC)) dut_b (
        .lpc_clk(clk), .lpc_lreset(rst), .bus(bus.slave), .code(b_code), .code_valid(b_cv),
        .write_count(b_wc), .abort_count(b_ac), .frame_active(b_fa));

    int checks = 0;
    int failures = 0;
    int a_p = 0, b_p = 0, ea_p = 0, eb_p = 0;
    logic [7:0] ea_code, eb_code, ea_wc, eb_wc, e_ac;

    always @(negedge clk) begin
        if (a_cv) a_p++;
        if (b_cv) b_p++;
    end

    task automatic model_reset();
        ea_code = 0; eb_code = 0; ea_wc = 0; eb_wc = 0; e_ac = 0;
        ea_p = 0; eb_p = 0; a_p = 0; b_p = 0;
    endtask

    task automatic drive(input logic lf, input logic [3:0] l);
        @(negedge clk);
        bus.lpc_lframe_n = lf;
        bus.lpc_lad = l;
    endtask

    task automatic settle();
        drive(1'b1, 4'hF);
        @(negedge clk);
        #1;
    endtask

    // cut = 7 means a complete frame; otherwise nibble cut is replaced by LFRAME# low with cut_lad
    task automatic frame(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                         input int cut, input logic [3:0] cut_lad, input int tail, input bit with_start);
        logic [3:0] nib [7];
        nib = '{ct, a[15:12], a[11:8], a[7:4], a[3:0], d[3:0], d[7:4]};
        if (with_start) drive(1'b0, 4'h0);
        for (int k = 0; k < 7; k++) begin
            if (k == cut) begin
                drive(1'b0, cut_lad);
                break;
            end
            drive(1'b1, nib[k]);
        end
        if (cut == 7 && ct == 4'h2) begin
            if (a == 16'h0080) begin ea_code = d; ea_wc++; ea_p++; end
            if (a >= 16'h0080 && a <= 16'h0083) begin eb_code = d; eb_wc++; eb_p++; end
        end else if (cut < 7 && cut_lad == 4'hF && (cut == 0 || ct == 4'h2) && e_ac != 8'hFF)
            e_ac++;
        for (int t = 0; t < tail; t++) drive(1'b1, 4'hF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.lpc_lframe_n = 1'b1;
        bus.lpc_lad = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (a_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", a_code); end
        checks++; if (a_cv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_cv); end
        checks++; if (a_wc !== 8'h00 || a_ac !== 8'h00) begin failures++; $display("FAIL reset_counts got=%h/%h exp=00/00", a_wc, a_ac); end
        checks++; if (a_fa !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", a_fa); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        frame(4'h2, 16'h0080, 8'h02, 7, 4'hF, 7, 1'b1);
        settle();
        checks++; if (a_code !== 8'h02) begin failures++; $display("FAIL basic_code got=%h exp=02", a_code); end
        checks++; if (a_p != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", a_p); end
        checks++; if (a_wc !== 8'd1 || a_ac !== 8'd0) begin failures++; $display("FAIL basic_counts got=%h/%h exp=01/00", a_wc, a_ac); end
    endtask

    task automatic test_frame_active();
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        #1;
        checks++; if (a_fa !== 1'b1) begin failures++; $display("FAIL active_ctdir got=%b exp=1", a_fa); end
        drive(1'b1, 4'hF);
        #1;
        checks++; if (a_fa !== 1'b0) begin failures++; $display("FAIL active_skip got=%b exp=0", a_fa); end
    endtask

    task automatic test_abort_after_tar();
        frame(4'h2, 16'h0080, 8'h5A, 7, 4'hF, 2, 1'b1);
        repeat (4) drive(1'b0, 4'hF);
        settle();
        checks++; if (a_code !== 8'h5A) begin failures++; $display("FAIL tar_abort_code got=%h exp=5a", a_code); end
        checks++; if (a_ac !== 8'd0 || a_fa !== 1'b0) begin failures++; $display("FAIL tar_abort_state got=%h/%b exp=00/0", a_ac, a_fa); end
    endtask

    task automatic test_mask();
        frame(4'h2, 16'h0081, 8'h77, 7, 4'hF, 3, 1'b1);
        settle();
        checks++; if (a_code !== ea_code || a_p != ea_p) begin failures++; $display("FAIL mask_exact got=%h/%0d exp=%h/%0d", a_code, a_p, ea_code, ea_p); end
        checks++; if (b_code !== 8'h77 || b_p != eb_p) begin failures++; $display("FAIL mask_wide got=%h/%0d exp=77/%0d", b_code, b_p, eb_p); end
    endtask

    task automatic test_nonwrite();
        frame(4'h0, 16'h0080, 8'hE1, 7, 4'hF, 3, 1'b1);
        frame(4'h6, 16'h0080, 8'hE2, 7, 4'hF, 3, 1'b1);
        settle();
        checks++; if (a_code !== ea_code || a_wc !== ea_wc || a_p != ea_p) begin failures++; $display("FAIL nonwrite got=%h/%h/%0d exp=%h/%h/%0d", a_code, a_wc, a_p, ea_code, ea_wc, ea_p); end
        checks++; if (a_fa !== 1'b0) begin failures++; $display("FAIL nonwrite_active got=%b exp=0", a_fa); end
    endtask

    task automatic test_abort();
        frame(4'h2, 16'h0080, 8'hAA, 4, 4'hF, 1, 1'b1);
        settle();
        checks++; if (a_ac !== 8'd1 || a_p != ea_p) begin failures++; $display("FAIL abort got=%h/%0d exp=01/%0d", a_ac, a_p, ea_p); end
        frame(4'h2, 16'h0080, 8'h3C, 7, 4'hF, 2, 1'b1);
        settle();
        checks++; if (a_code !== 8'h3C || a_p != ea_p) begin failures++; $display("FAIL abort_recover got=%h/%0d exp=3c/%0d", a_code, a_p, ea_p); end
    endtask

    task automatic test_override();
        frame(4'h2, 16'h0080, 8'h11, 6, 4'h0, 0, 1'b1);
        frame(4'h2, 16'h0080, 8'h99, 7, 4'hF, 2, 1'b0);
        settle();
        checks++; if (a_code !== 8'h99 || a_p != ea_p || a_ac !== e_ac) begin failures++; $display("FAIL override got=%h/%0d/%h exp=99/%0d/%h", a_code, a_p, a_ac, ea_p, e_ac); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h2);
        drive(1'b1, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0);
        drive(1'b1, 4'h5);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(1'b1, 4'h6);
        #1;
        model_reset();
        checks++; if (a_code !== 8'h00 || a_cv !== 1'b0 || a_fa !== 1'b0) begin failures++; $display("FAIL reset_mid_out got=%h/%b/%b exp=00/0/0", a_code, a_cv, a_fa); end
        checks++; if (a_wc !== 8'h00 || a_ac !== 8'h00) begin failures++; $display("FAIL reset_mid_counts got=%h/%h exp=00/00", a_wc, a_ac); end
        @(negedge clk);
        rst = 1'b0;
        settle();
        checks++; if (a_p != 0 || a_wc !== 8'h00) begin failures++; $display("FAIL reset_mid_after got=%0d/%h exp=0/00", a_p, a_wc); end
    endtask

    task automatic test_long_start();
        drive(1'b0, 4'h0);
        drive(1'b0, 4'h0);
        frame(4'h2, 16'h0080, 8'hC7, 7, 4'hF, 2, 1'b1);
        settle();
        checks++; if (a_code !== 8'hC7 || a_wc !== ea_wc || a_p != ea_p) begin failures++; $display("FAIL long_start got=%h/%h/%0d exp=c7/%h/%0d", a_code, a_wc, a_p, ea_wc, ea_p); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) frame(4'h2, 16'h0080 + 16'(i), 8'($urandom), 7, 4'hF, 0, 1'b1);
        settle();
        checks++; if (a_code !== ea_code || b_code !== eb_code || b_p != eb_p) begin failures++; $display("FAIL back_to_back got=%h/%h/%0d exp=%h/%h/%0d", a_code, b_code, b_p, ea_code, eb_code, eb_p); end
    endtask

    task automatic test_random();
        logic [3:0] cts [6];
        logic [3:0] ct, cl;
        logic [15:0] a;
        int cut;
        cts = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h6, 4'h3};
        for (int i = 0; i < 60; i++) begin
            ct = cts[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0: a = 16'h0080;
                1: a = 16'h0081;
                2: a = 16'h0083;
                default: a = 16'($urandom);
            endcase
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 7;
            cl = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
            frame(ct, a, 8'($urandom), cut, cl, $urandom_range(0, 3), 1'b1);
            settle();
            checks++;
            if (a_code !== ea_code || a_wc !== ea_wc || a_ac !== e_ac || a_p != ea_p ||
                b_code !== eb_code || b_wc !== eb_wc || b_ac !== e_ac || b_p != eb_p) begin
                failures++;
                $display("FAIL random_%0d got a=%h/%h/%h/%0d b=%h/%h/%h/%0d exp a=%h/%h/%h/%0d b=%h/%h/%h/%0d", i,
                         a_code, a_wc, a_ac, a_p, b_code, b_wc, b_ac, b_p,
                         ea_code, ea_wc, e_ac, ea_p, eb_code, eb_wc, e_ac, eb_p);
            end
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) frame(4'h2, 16'h0080, 8'(i), 7, 4'hF, 0, 1'b1);
        settle();
        checks++; if (a_wc !== 8'h00 || a_wc !== ea_wc) begin failures++; $display("FAIL wrap_count got=%h exp=00", a_wc); end
        checks++; if (a_p != 256 || a_code !== 8'hFF) begin failures++; $display("FAIL wrap_pulses got=%0d/%h exp=256/ff", a_p, a_code); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_active();
        test_abort_after_tar();
        test_mask();
        test_nonwrite();
        test_abort();
        test_override();
        test_reset_mid();
        test_long_start();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
